// File: rtl/commit_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_queue
// Brief    : Packs per-cycle retirement and trap events, in program order,
//            into a FIFO drained one record per cycle by a lock-step checker.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_queue #(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMITS-1:0]      in_valid,
    input  logic [64*COMMITS-1:0]   in_pc,
    input  logic [32*COMMITS-1:0]   in_insn,
    input  logic [COMMITS-1:0]      in_wen,
    input  logic [5*COMMITS-1:0]    in_waddr,
    input  logic [64*COMMITS-1:0]   in_wdata,
    input  logic                    in_trap_valid,
    input  logic [63:0]             in_trap_cause,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_kind,
    output logic [63:0]             out_pc,
    output logic [31:0]             out_insn,
    output logic                    out_wen,
    output logic [4:0]              out_waddr,
    output logic [63:0]             out_wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_NW = $clog2(COMMITS + 2);
    localparam logic [c_PW-1:0] c_DEPTH    = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_AF_LIMIT = c_PW'(DEPTH - COMMITS - 1);

    // Record storage; contents are don't-care until written, so no reset.
    logic         r_kind  [0:DEPTH-1];
    logic [63:0]  r_pc    [0:DEPTH-1];
    logic [31:0]  r_insn  [0:DEPTH-1];
    logic         r_wen   [0:DEPTH-1];
    logic [4:0]   r_waddr [0:DEPTH-1];
    logic [63:0]  r_wdata [0:DEPTH-1];

    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW-1:0] r_count;
    logic            r_almost_full;
    logic            r_overflow;

    logic [c_NW-1:0] w_pop;
    logic [c_NW-1:0] w_n;
    logic [c_AW-1:0] w_widx [0:COMMITS-1];
    logic [c_AW-1:0] w_tidx;
    logic [c_AW-1:0] w_ridx;
    logic [c_PW-1:0] w_free;
    logic [c_PW-1:0] w_push;
    logic [c_PW-1:0] w_count_next;
    logic            w_accept;
    logic            w_deq;
    logic            w_out_valid;

    // Each valid slot lands at wptr + (number of valid slots below it), which
    // compacts the slots with no gaps; the trap goes after all of them.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < COMMITS; i++) begin
            w_widx[i] = r_wptr[c_AW-1:0] + c_AW'(w_pop);
            w_pop     = w_pop + c_NW'(in_valid[i]);
        end
        w_tidx = r_wptr[c_AW-1:0] + c_AW'(w_pop);
        w_n    = w_pop + c_NW'(in_trap_valid);
    end

    // Free space ignores a same-cycle dequeue: a cycle either fits entirely
    // in what is free now, or every one of its records is dropped.
    assign w_free       = c_DEPTH - r_count;
    assign w_accept     = (c_PW'(w_n) <= w_free);
    assign w_push       = w_accept ? c_PW'(w_n) : '0;
    assign w_out_valid  = (r_rptr != r_wptr);
    assign w_deq        = w_out_valid & out_ready;
    assign w_count_next = r_count + w_push - c_PW'(w_deq);
    assign w_ridx       = r_rptr[c_AW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wptr        <= r_wptr + w_push;
            r_rptr        <= r_rptr + c_PW'(w_deq);
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next > c_AF_LIMIT);
            if (!w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i]) begin
                    r_kind[w_widx[i]]  <= 1'b0;
                    r_pc[w_widx[i]]    <= in_pc[64*i +: 64];
                    r_insn[w_widx[i]]  <= in_insn[32*i +: 32];
                    r_wen[w_widx[i]]   <= in_wen[i];
                    r_waddr[w_widx[i]] <= in_waddr[5*i +: 5];
                    r_wdata[w_widx[i]] <= in_wdata[64*i +: 64];
                end
            end
            if (in_trap_valid) begin
                r_kind[w_tidx]  <= 1'b1;
                r_pc[w_tidx]    <= '0;
                r_insn[w_tidx]  <= '0;
                r_wen[w_tidx]   <= 1'b0;
                r_waddr[w_tidx] <= '0;
                r_wdata[w_tidx] <= in_trap_cause;
            end
        end
    end

    assign out_valid   = w_out_valid;
    assign out_kind    = w_out_valid ? r_kind[w_ridx]  : 1'b0;
    assign out_pc      = w_out_valid ? r_pc[w_ridx]    : '0;
    assign out_insn    = w_out_valid ? r_insn[w_ridx]  : '0;
    assign out_wen     = w_out_valid ? r_wen[w_ridx]   : 1'b0;
    assign out_waddr   = w_out_valid ? r_waddr[w_ridx] : '0;
    assign out_wdata   = w_out_valid ? r_wdata[w_ridx] : '0;
    assign count       = r_count;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_queue
// Brief    : Directed self-checking bench for commit_trace_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_queue;

    localparam int C = 2;
    localparam int D = 16;

    logic              clock;
    logic              reset;
    logic [C-1:0]      in_valid;
    logic [64*C-1:0]   in_pc;
    logic [32*C-1:0]   in_insn;
    logic [C-1:0]      in_wen;
    logic [5*C-1:0]    in_waddr;
    logic [64*C-1:0]   in_wdata;
    logic              in_trap_valid;
    logic [63:0]       in_trap_cause;
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [63:0]       out_pc;
    logic [31:0]       out_insn;
    logic              out_wen;
    logic [4:0]        out_waddr;
    logic [63:0]       out_wdata;
    logic [4:0]        count;
    logic              almost_full;
    logic              overflow;

    int vectors     = 0;
    int miscompares = 0;

    commit_trace_queue #(.COMMITS(C), .DEPTH(D)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_insn       (in_insn),
        .in_wen        (in_wen),
        .in_waddr      (in_waddr),
        .in_wdata      (in_wdata),
        .in_trap_valid (in_trap_valid),
        .in_trap_cause (in_trap_cause),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_kind      (out_kind),
        .out_pc        (out_pc),
        .out_insn      (out_insn),
        .out_wen       (out_wen),
        .out_waddr     (out_waddr),
        .out_wdata     (out_wdata),
        .count         (count),
        .almost_full   (almost_full),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in;
        in_valid      = '0;
        in_pc         = '0;
        in_insn       = '0;
        in_wen        = '0;
        in_waddr      = '0;
        in_wdata      = '0;
        in_trap_valid = 1'b0;
        in_trap_cause = '0;
    endtask

    task automatic set_slot(input int i, input logic [63:0] pc, input logic [31:0] insn,
                            input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
        in_valid[i]          = 1'b1;
        in_pc[64*i +: 64]    = pc;
        in_insn[32*i +: 32]  = insn;
        in_wen[i]            = wen;
        in_waddr[5*i +: 5]   = waddr;
        in_wdata[64*i +: 64] = wdata;
    endtask

    initial begin
        int id_next;
        int cyc;
        int s0;
        int e;
        int mask;
        int expq[$];

        clock     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b0;
        clear_in();

        // Reset state
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wdata", out_wdata, 0);
        reset = 1'b0;
        tick();

        // Single commit, consumed the cycle after capture
        out_ready = 1'b1;
        set_slot(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        clear_in();
        chk("one_valid", out_valid, 1);
        chk("one_kind", out_kind, 0);
        chk("one_pc", out_pc, 64'h8000_0000);
        chk("one_insn", out_insn, 32'h0000_0013);
        chk("one_count", count, 1);
        tick();
        chk("one_count_after", count, 0);
        chk("one_valid_after", out_valid, 0);
        chk("one_pc_forced", out_pc, 0);

        // Compaction and ordering, trap last
        set_slot(1, 64'h104, 32'h0000_0093, 1'b1, 5'd5, 64'hAAAA);
        tick();
        clear_in();
        set_slot(0, 64'h108, 32'h0000_0113, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'h10C, 32'h0000_0193, 1'b0, 5'd0, 64'd0);
        in_trap_valid = 1'b1;
        in_trap_cause = 64'd2;
        chk("cmp_pc0", out_pc, 64'h104);
        chk("cmp_wen0", out_wen, 1);
        chk("cmp_waddr0", out_waddr, 5);
        chk("cmp_wdata0", out_wdata, 64'hAAAA);
        tick();
        clear_in();
        chk("cmp_pc1", out_pc, 64'h108);
        chk("cmp_count", count, 3);
        tick();
        chk("cmp_pc2", out_pc, 64'h10C);
        tick();
        chk("cmp_trap_kind", out_kind, 1);
        chk("cmp_trap_cause", out_wdata, 64'd2);
        chk("cmp_trap_pc", out_pc, 0);
        tick();
        chk("cmp_count_end", count, 0);

        // Fill to full with two commits per cycle
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_slot(0, 64'h1000 + 64'(8*k), 32'h13, 1'b0, 5'd0, 64'd0);
            set_slot(1, 64'h1004 + 64'(8*k), 32'h13, 1'b0, 5'd0, 64'd0);
            tick();
            clear_in();
            if (k == 5) chk("full_af_12", almost_full, 0);
            if (k == 6) chk("full_af_14", almost_full, 1);
        end
        chk("full_count", count, 16);
        chk("full_ovf_clear", overflow, 0);
        set_slot(0, 64'hDEAD, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_in();
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_head", out_pc, 64'h1000);

        // Partial fit at count 15 with a concurrent dequeue
        out_ready = 1'b1;
        tick();
        chk("pf_count15", count, 15);
        set_slot(0, 64'hBEEF0, 32'h13, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'hBEEF4, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_in();
        chk("pf_count14", count, 14);
        chk("pf_ovf", overflow, 1);
        for (int j = 2; j < 16; j++) begin
            chk("drain_pc", out_pc, 64'h1000 + 64'(4*j));
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_valid", out_valid, 0);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        set_slot(0, 64'h3000, 32'h13, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'h3004, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        tick();
        clear_in();
        set_slot(0, 64'h3010, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_in();
        chk("ar_count5", count, 5);
        chk("ar_ovf_before", overflow, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_ovf", overflow, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        chk("ar_valid_after", out_valid, 0);

        // Wrap-around stream with random back-pressure
        id_next = 0;
        cyc     = 0;
        while ((id_next < 40 || expq.size() != 0) && cyc < 2000) begin
            s0 = expq.size();
            chk("wrap_count", count, 64'(s0));
            chk("wrap_valid", out_valid, (s0 != 0));
            out_ready = 1'($urandom_range(0, 1));
            if (out_ready && s0 != 0) begin
                e = expq.pop_front();
                chk("wrap_pc", out_pc, 64'h2000 + 64'(4*e));
                chk("wrap_wdata", out_wdata, 64'h1111 * 64'(e));
            end
            clear_in();
            mask = $urandom_range(0, 3);
            if (s0 <= D - (C + 1)) begin
                for (int i = 0; i < C; i++) begin
                    if (mask[i] && id_next < 40) begin
                        set_slot(i, 64'h2000 + 64'(4*id_next), 32'h13, 1'b1, 5'(id_next),
                                 64'h1111 * 64'(id_next));
                        expq.push_back(id_next);
                        id_next++;
                    end
                end
            end
            tick();
            cyc++;
        end
        clear_in();
        chk("wrap_in_time", (cyc < 2000), 1);
        chk("wrap_all_sent", id_next, 40);
        chk("wrap_final_count", count, 0);
        chk("wrap_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/commit_trace_queue.md
# commit_trace_queue

DUT-side producer for the Spike lock-step co-simulation checker. Captures up to `COMMITS` retirement events plus one trap event per cycle from the core's commit stage, then packs them in program order into a FIFO. It presents them one record per cycle over a valid/ready port to the checker harness, which drives `cosim_commit`, `cosim_judge` and `cosim_raise_trap`. Retirement cannot be stalled, so overflow is detected and flagged rather than back-pressured.

## Interface
- `COMMITS`, 2: commit slots per cycle, 1..4.
- `DEPTH`, 16: FIFO entries; power of two, at least 2*(`COMMITS`+1).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in `COMMITS`: slot i retired an instruction this cycle.
- `in_pc` in 64*`COMMITS`: retired PC, slot i at bits [64i+63:64i].
- `in_insn` in 32*`COMMITS`: retired instruction word.
- `in_wen` in `COMMITS`: slot i wrote an integer register.
- `in_waddr` in 5*`COMMITS`: destination register.
- `in_wdata` in 64*`COMMITS`: written value.
- `in_trap_valid` in 1: trap taken this cycle, ordered after all slots.
- `in_trap_cause` in 64: trap cause (mcause encoding).
- `out_valid` out 1: head record available.
- `out_ready` in 1: checker consumes head record.
- `out_kind` out 1: 0 = commit record, 1 = trap record.
- `out_pc` out 64, `out_insn` out 32, `out_wen` out 1, `out_waddr` out 5: commit fields; all 0 for trap records.
- `out_wdata` out 64: write data for commits; cause for traps.
- `count` out log2(`DEPTH`)+1: occupied entries.
- `almost_full` out 1: `count` > `DEPTH` - (`COMMITS`+1).
- `overflow` out 1: sticky; a cycle's events were dropped.

## Operation
- Per-cycle record list: valid slots in ascending slot index, compacted with no gaps. A trap record follows if `in_trap_valid`. Needed entries n = popcount(`in_valid`) + `in_trap_valid`, range 0..`COMMITS`+1.
- Admission is all-or-nothing. Free space is `DEPTH`-`count`, measured at the start of the cycle with no credit for a same-cycle dequeue. If n exceeds free space, all n records are dropped and `overflow` sets to 1, staying 1 until reset. Otherwise all n are written at wptr, wptr+1, … (mod `DEPTH`).
- Dequeue occurs when `out_valid` and `out_ready` are both 1. rptr then advances by 1.
- Pointers are log2(`DEPTH`)+1 bits with a wrap bit. Empty is rptr==wptr. `count` = wptr-rptr, modulo 2^(log2(`DEPTH`)+1).
- Same-cycle enqueue and dequeue: `count` next = `count` + n − deq. A full FIFO with a dequeue this cycle still rejects n≥1.
- `out_*` fields reflect the storage at rptr while `out_valid` is 1, and are forced to 0 while it is 0.
- `out_ready` while `out_valid` is 0 has no effect.
- Events never reorder. Entries dropped on overflow are never partially visible.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert by the environment) clears the pointers to 0 and sets `out_valid`=0, all `out_*` to 0, `count`=0, `almost_full`=0 and `overflow`=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all queued records immediately, without waiting for a clock edge.
- Latency: a record captured at edge k is visible on `out_*` with `out_valid`=1 after edge k, so a consumer can take it in cycle k+1. In steady state, with `out_ready`=1, throughput is 1 record per cycle.
- `count`, `almost_full` and `overflow` are registered and update at the same edge as the pointers.
- Head output is a combinational read of registered storage at rptr. There is no combinational path from `in_*` to `out_*`.

## Test plan
- Single commit: slot0 valid, pc=0x80000000, insn=0x00000013, wen=0, with `out_ready`=1. One cycle later `out_valid`=1, `out_kind`=0, `out_pc`=0x80000000. The following cycle `count` returns to 0.
- Compaction and order: slot1 only valid (pc=0x104) in cycle A, then slot0 (pc=0x108), slot1 (pc=0x10C) and a trap with cause=2 in cycle B, with `out_ready` held 1. Output sequence is 0x104, 0x108, 0x10C, then a trap record with `out_wdata`=2.
- Full/overflow: `out_ready`=0 while 2 commits/cycle are pushed to `DEPTH`=16. `almost_full` rises at `count`=14. At `count`=16 a 1-commit cycle is dropped and `overflow`=1, with `count` staying at 16 and the FIFO contents unchanged.
- Partial fit rejected: at `count`=15, push 2 commits while `out_ready`=1. Both are dropped, `overflow`=1 and `count`=14.
- Wrap-around: 40 records are streamed with random `out_ready`. All 40 emerge in order and intact, and `count` never exceeds 16.
- Async reset: assert `reset` between edges with `count`=5. `out_valid`, `count` and `overflow` read 0 before the next rising edge.
